// File: rtl/freq_meas_sequencer.sv
// freq_meas_sequencer: round-robins enabled sources through the frequency counter,
// latching each result (or a timeout) and holding it for a dwell period.
module freq_meas_sequencer #(
  parameter int NUM_SRC     = 4,
  parameter int RES_W       = 16,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int DWELL_CYC   = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_SRC-1:0]         src_mask,
  input  logic [NUM_SRC-1:0]         sig_in,
  output logic                       meas_sig,
  output logic                       meas_start,
  input  logic                       meas_done,
  input  logic [RES_W-1:0]           meas_result,
  output logic [$clog2(NUM_SRC)-1:0] cur_sel,
  output logic                       res_valid,
  output logic [RES_W-1:0]           res_data,
  output logic [$clog2(NUM_SRC)-1:0] res_src,
  output logic                       timeout,
  output logic                       busy
);
  localparam int SW   = $clog2(NUM_SRC);
  localparam int SETW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  localparam int TW   = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int DW   = DWELL_CYC > 1 ? $clog2(DWELL_CYC) : 1;
  localparam logic [2:0] IDLE = 3'd0, SELECT = 3'd1, SETTLE = 3'd2,
                         START = 3'd3, WAIT = 3'd4, DWELL = 3'd5;
  logic [2:0]       state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d, last_q, last_d, rsrc_q, rsrc_d, nxt_sel;
  logic [SETW-1:0]  scnt_q, scnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [RES_W-1:0] rdata_q, rdata_d;
  logic             start_q, valid_q, valid_d, tout_q, tout_d, busy_q;
  // Descending scan so the nearest set bit after last_q wins; k=NUM_SRC lands on last_q itself.
  always_comb begin
    nxt_sel = last_q;
    for (int k = NUM_SRC; k >= 1; k--)
      if (src_mask[(int'(last_q) + k) % NUM_SRC]) nxt_sel = SW'((int'(last_q) + k) % NUM_SRC);
  end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    rsrc_d  = rsrc_q;
    rdata_d = rdata_q;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    valid_d = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      IDLE:    state_d = (en && |src_mask) ? SELECT : IDLE;
      SELECT: begin
        state_d = (en && |src_mask) ? SETTLE : IDLE;
        sel_d   = (en && |src_mask) ? nxt_sel : sel_q;
        scnt_d  = SETW'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        state_d = !en ? IDLE : (scnt_q == '0) ? START : SETTLE;
        scnt_d  = (scnt_q == '0) ? scnt_q : scnt_q - 1'b1;
      end
      START: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (meas_done) begin
          rdata_d = meas_result;
          rsrc_d  = sel_q;
          valid_d = 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          tout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
        if (meas_done || tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          last_d  = sel_q;
          dcnt_d  = DW'(DWELL_CYC - 1);
          state_d = DWELL;
        end
      end
      DWELL: begin
        state_d = (dcnt_q != '0) ? DWELL : en ? SELECT : IDLE;
        dcnt_d  = (dcnt_q == '0) ? dcnt_q : dcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SW'(NUM_SRC - 1);
      rsrc_q  <= '0;
      rdata_q <= '0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rsrc_q  <= rsrc_d;
      rdata_q <= rdata_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
      start_q <= (state_d == START) && (state_q != START);
      valid_q <= valid_d;
      tout_q  <= tout_d;
      busy_q  <= state_d != IDLE;
    end
  end
  assign meas_sig   = sig_in[sel_q];
  assign meas_start = start_q;
  assign cur_sel    = sel_q;
  assign res_valid  = valid_q;
  assign res_data   = rdata_q;
  assign res_src    = rsrc_q;
  assign timeout    = tout_q;
  assign busy       = busy_q;
endmodule
